serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Sequencer that performs multi-bit addition by time-multiplexing a single 1-bit full-adder datapath, built from two half-adder cells plus an OR, across consecutive cycles, LSB first. Operands are taken in through a val/rdy input interface and the result is returned through a val/rdy output interface. The block sits between a requester and the shared bit-level adder gates. It trades throughput for area in the comb-gates adder family.

## Interface
- nbits, 8, operand/result width; legal range 2..32
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; state clears immediately when low
- in_val  input  1  operands valid
- in_rdy  output  1  block can accept operands
- in_a  input  nbits  operand A
- in_b  input  nbits  operand B
- out_val  output  1  result valid
- out_rdy  input  1  consumer can accept result
- out_sum  output  nbits  sum bits
- out_cout  output  1  carry out of MSB

## Operation
- State machine with states IDLE, CALC and DONE. Reset state is IDLE.
- Internal registers:
  - a_reg and b_reg: shift right by 1 each CALC cycle.
  - carry: 1 bit.
  - sum_reg: nbits wide.
  - idx: bit counter, $clog2(nbits) bits.
- IDLE:
  - in_rdy=1.
  - On in_val && in_rdy: load a_reg=in_a, b_reg=in_b, carry=0, sum_reg=0, idx=0; go to CALC.
- CALC, once per cycle:
  - Compute s = a_reg[0]^b_reg[0]^carry.
  - Compute c = (a_reg[0]&b_reg[0]) | (carry&(a_reg[0]^b_reg[0])).
  - Write sum_reg[idx]=s, carry=c, shift a_reg/b_reg right with zero fill, idx+=1.
  - When idx==nbits-1, go to DONE after this cycle.
- DONE:
  - out_val=1, out_sum=sum_reg, out_cout=carry.
  - On out_val && out_rdy, go to IDLE.
  - Hold outputs stable indefinitely while out_rdy=0.
- in_rdy=0 in CALC and DONE. in_val is ignored outside IDLE; no input buffering.
- Arithmetic is unsigned modulo 2^nbits. out_cout is the true carry out of bit nbits-1.
- out_sum and out_cout are held at their last values outside DONE; they are don't-care while out_val=0.

## Timing
- Reset values: state=IDLE, in_rdy=1, out_val=0, out_sum=0, out_cout=0, carry=0, idx=0.
- Acceptance on edge k: CALC is active for edges k+1 through k+nbits. out_val is asserted after edge k+nbits.
- Latency from acceptance edge to out_val: nbits cycles.
- Output transfer on edge m: in_rdy=1 after edge m. The earliest next acceptance is edge m+1.
- Max throughput: one result per nbits+2 cycles.
- in_rdy and out_val are registered-state decodes only, with no combinational path from in_val or out_rdy.
- Reset asserted mid-CALC or in DONE: the block returns to IDLE immediately and the in-flight operation is discarded; out_val drops without a handshake.
- in_val held high during CALC/DONE: no effect. A new transaction is accepted only in IDLE.

## Configuration
- SERIAL_ADDER_CTRL_EARLY_EXIT_EN
  - Defined: after each CALC cycle, if the shifted a_reg==0, b_reg==0 and the new carry==0, go to DONE immediately even if idx<nbits-1. Unwritten sum bits remain 0 and out_cout=0. Latency becomes 1..nbits cycles: the position of the highest nonzero operand bit plus carry propagation, plus one.
  - Undefined: latency is always exactly nbits cycles.
  - Result values are identical in both builds.

## Test plan
All scenarios use nbits=8.
- Reset then idle: after reset release, in_rdy=1, out_val=0, out_sum=0x00, out_cout=0. Hold 5 cycles with in_val=0 and verify no change.
- Basic add: a=0x05, b=0x03 -> out_sum=0x08, out_cout=0.
  - Without EARLY_EXIT_EN, out_val rises exactly 8 cycles after acceptance.
  - With EARLY_EXIT_EN, it rises 4 cycles after acceptance.
- Full carry ripple: a=0xFF, b=0x01 -> out_sum=0x00, out_cout=1, 8-cycle latency in both builds. Also a=0x80, b=0x80 -> 0x00, cout=1.
- Backpressure: a=0xA5, b=0x5A with out_rdy=0 for 6 cycles after out_val -> out_sum=0xFF and cout=0 held stable and in_rdy=0 throughout. Raise out_rdy, then in_rdy=1 next cycle.
- Back-to-back with in_val held high: send 0x10+0x20 then 0x7F+0x01 -> 0x30/0, then 0x80/0. The second transaction is accepted one cycle after the first output transfer.
- Reset mid-operation: accept 0xC3+0x3C, pull reset low during the 4th CALC cycle -> out_val=0 and in_rdy=1 immediately. After release, 0x01+0x02 -> 0x03 with normal latency.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// master drives operands and result-ready; slave is the adder sequencer.
interface serial_adder_ctrl_if #(
    parameter int nbits = 8
);
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_a;
    logic [nbits-1:0] in_b;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_val,
        output in_a,
        output in_b,
        output out_rdy,
        input  in_rdy,
        input  out_val,
        input  out_sum,
        input  out_cout
    );

    modport slave (
        input  in_val,
        input  in_a,
        input  in_b,
        input  out_rdy,
        output in_rdy,
        output out_val,
        output out_sum,
        output out_cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full adder (two half adders + OR), LSB first.
// Optional SERIAL_ADDER_CTRL_EARLY_EXIT_EN stops once operands and carry drain.
module serial_adder_ctrl #(
    parameter int nbits = 8
) (
    input logic               clk,
    input logic               reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int IW = $clog2(nbits);
    localparam logic [IW-1:0] LAST = IW'(nbits - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [nbits-1:0] a_reg;
    logic [nbits-1:0] b_reg;
    logic [nbits-1:0] sum_reg;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [nbits-1:0] out_sum_q;
    logic             out_cout_q;

    logic             load;
    logic             step;
    logic             last;
    logic             drained;
    logic [nbits-1:0] a_shift;
    logic [nbits-1:0] b_shift;
    logic [nbits-1:0] sum_next;

    logic [1:0] ha0;
    logic [1:0] ha1;
    logic       bit_sum;
    logic       bit_cout;

    // {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    assign ha0      = half_add(a_reg[0], b_reg[0]);
    assign ha1      = half_add(ha0[0], carry);
    assign bit_sum  = ha1[0];
    assign bit_cout = ha0[1] | ha1[1];

    assign a_shift = a_reg >> 1;
    assign b_shift = b_reg >> 1;
    assign last    = (idx == LAST);

`ifdef SERIAL_ADDER_CTRL_EARLY_EXIT_EN
    // Nothing left to add: remaining sum bits stay zero.
    assign drained = (a_shift == '0) && (b_shift == '0) && !bit_cout;
`else
    assign drained = 1'b0;
`endif

    always_comb begin
        sum_next      = sum_reg;
        sum_next[idx] = bit_sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_val) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last || drained) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else if (load) begin
            a_reg   <= bus.in_a;
            b_reg   <= bus.in_b;
            sum_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
        end else if (step) begin
            a_reg   <= a_shift;
            b_reg   <= b_shift;
            sum_reg <= sum_next;
            carry   <= bit_cout;
            idx     <= idx + 1'b1;
            // Result registers only move on entry to DONE.
            if (state_d == DONE) begin
                out_sum_q  <= sum_next;
                out_cout_q <= bit_cout;
            end
        end
    end

    assign bus.in_rdy   = (state_q == IDLE);
    assign bus.out_val  = (state_q == DONE);
    assign bus.out_sum  = out_sum_q;
    assign bus.out_cout = out_cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with nbits=8.
// Latency expectations follow SERIAL_ADDER_CTRL_EARLY_EXIT_EN.
module tb_serial_adder_ctrl;
    localparam int NB = 8;
`ifdef SERIAL_ADDER_CTRL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    int   lat;

    serial_adder_ctrl_if #(.nbits(NB)) bus ();

    serial_adder_ctrl #(.nbits(NB)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_val = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_val(output int n);
        n = 0;
        while (bus.out_val !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic take();
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.in_val  = 1'b0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_rdy", bus.in_rdy, 1);
        check("rst_out_val", bus.out_val, 0);
        check("rst_out_sum", bus.out_sum, 8'h00);
        check("rst_out_cout", bus.out_cout, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("idle_in_rdy", bus.in_rdy, 1);
            check("idle_out_val", bus.out_val, 0);
        end

        // 0x05 + 0x03
        offer(8'h05, 8'h03);
        bus.in_val = 1'b0;
        check("basic_busy", bus.in_rdy, 0);
        wait_val(lat);
        check("basic_lat", lat, EE ? 4 : 8);
        check("basic_sum", bus.out_sum, 8'h08);
        check("basic_cout", bus.out_cout, 0);
        take();
        check("basic_xfer_rdy", bus.in_rdy, 1);
        check("basic_xfer_val", bus.out_val, 0);

        // full ripple
        offer(8'hFF, 8'h01);
        bus.in_val = 1'b0;
        wait_val(lat);
        check("ripple_lat", lat, 8);
        check("ripple_sum", bus.out_sum, 8'h00);
        check("ripple_cout", bus.out_cout, 1);
        take();

        offer(8'h80, 8'h80);
        bus.in_val = 1'b0;
        wait_val(lat);
        check("msb_lat", lat, 8);
        check("msb_sum", bus.out_sum, 8'h00);
        check("msb_cout", bus.out_cout, 1);
        take();

        // backpressure
        offer(8'hA5, 8'h5A);
        bus.in_val = 1'b0;
        wait_val(lat);
        check("bp_lat", lat, 8);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("bp_val", bus.out_val, 1);
            check("bp_sum", bus.out_sum, 8'hFF);
            check("bp_cout", bus.out_cout, 0);
            check("bp_in_rdy", bus.in_rdy, 0);
        end
        take();
        check("bp_rdy_after", bus.in_rdy, 1);

        // back-to-back, in_val held
        offer(8'h10, 8'h20);
        check("b2b_busy", bus.in_rdy, 0);
        bus.in_a = 8'h7F;
        bus.in_b = 8'h01;
        wait_val(lat);
        check("b2b1_lat", lat, EE ? 6 : 8);
        check("b2b1_sum", bus.out_sum, 8'h30);
        check("b2b1_cout", bus.out_cout, 0);
        take();
        check("b2b_idle_rdy", bus.in_rdy, 1);
        @(posedge clk);
        #1;
        check("b2b_accept", bus.in_rdy, 0);
        bus.in_val = 1'b0;
        wait_val(lat);
        check("b2b2_lat", lat, 8);
        check("b2b2_sum", bus.out_sum, 8'h80);
        check("b2b2_cout", bus.out_cout, 0);
        take();

        // reset during 4th CALC cycle
        offer(8'hC3, 8'h3C);
        bus.in_val = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_val", bus.out_val, 0);
        check("mid_rst_rdy", bus.in_rdy, 1);
        check("mid_rst_sum", bus.out_sum, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        offer(8'h01, 8'h02);
        bus.in_val = 1'b0;
        wait_val(lat);
        check("post_rst_lat", lat, EE ? 2 : 8);
        check("post_rst_sum", bus.out_sum, 8'h03);
        check("post_rst_cout", bus.out_cout, 0);
        take();
        check("post_rst_rdy", bus.in_rdy, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
